// File: rtl/trigout_pkg.sv
// Shared definitions for the programmable trigger-out delay line.
package trigout_pkg;

  localparam int   DEPTH_DEFAULT = 32;
  localparam logic MODE_LEVEL    = 1'b0;
  localparam logic MODE_EDGE     = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trigout_delay_ram.sv
// WIDTH x DEPTH circular sample buffer; read tap sits (dreg-1) slots behind the write pointer.
module trigout_delay_ram
  import trigout_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = clog2(DEPTH),
  localparam int DW    = clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [DW-1:0]    dreg_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_offset;
  logic [AW-1:0]    rd_addr;

  assign rd_offset = AW'(dreg_i - DW'(1));
  assign rd_addr   = wr_ptr_q - rd_offset;
  // A one-cycle delay reads the slot being written this edge, so take Din directly.
  assign rd_data_o = (rd_offset == '0) ? din_i : mem_q[rd_addr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wr_ptr_q <= '0;
    else          wr_ptr_q <= wr_ptr_q + AW'(1);
  end

  always_ff @(posedge clk_i) begin
    mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/prog_trigout_delay.sv
// Runtime-programmable 1..DEPTH cycle delay for a trigger/data bus, with fill-valid and edge-pulse mode.
module prog_trigout_delay
  import trigout_pkg::*;
#(
  parameter  int WIDTH       = 1,
  parameter  int DEPTH       = DEPTH_DEFAULT,
  parameter  int RESET_DELAY = 32,
  localparam int DW          = clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [DW-1:0]    delay_i,
  input  logic             load_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o
);

  logic [DW-1:0]    dreg_q, dreg_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] delayed, gated, p_eff;

  trigout_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .din_i     (din_i),
    .dreg_i    (dreg_d),
    .rd_data_o (delayed)
  );

  always_comb begin
    dreg_d = dreg_q;
    if (load_i) begin
      if (delay_i == '0)              dreg_d = DW'(1);
      else if (delay_i > DW'(DEPTH))  dreg_d = DW'(DEPTH);
      else                            dreg_d = delay_i;
    end

    // The capturing edge counts as the first filled sample.
    if (load_i)               fill_d = DW'(1);
    else if (fill_q < dreg_d) fill_d = fill_q + DW'(1);
    else                      fill_d = fill_q;

    valid_d = (fill_d >= dreg_d);
    gated   = valid_d ? delayed : '0;
    // History only follows post-load samples, so a level high at Valid rise pulses once.
    p_eff   = load_i ? '0 : p_q;
    p_d     = gated;
    dout_d  = (mode_i == MODE_EDGE) ? (gated & ~p_eff) : gated;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dreg_q  <= DW'(RESET_DELAY);
      fill_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      p_q     <= '0;
    end else begin
      dreg_q  <= dreg_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      p_q     <= p_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_prog_trigout_delay.sv
// Randomised bench for prog_trigout_delay against a sample-history reference model.
module tb_prog_trigout_delay;

  localparam int W   = 8;
  localparam int DEP = 32;
  localparam int RD  = 32;
  localparam int HN  = 4096;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic [W-1:0] din_i = '0;
  logic [5:0]   delay_i = '0;
  logic         load_i = 1'b0;
  logic         mode_i = 1'b0;
  logic [W-1:0] dout_o;
  logic         valid_o;

  int errors = 0;
  int checks = 0;

  // Reference model: every sampled Din by edge number, plus the current fill segment.
  logic [W-1:0] hist [HN];
  int           e;
  int           seg_start;
  int           cur_d;
  logic [W-1:0] exp_dout;
  logic         exp_valid;

  prog_trigout_delay #(
    .WIDTH       (W),
    .DEPTH       (DEP),
    .RESET_DELAY (RD)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .din_i   (din_i),
    .delay_i (delay_i),
    .load_i  (load_i),
    .mode_i  (mode_i),
    .dout_o  (dout_o),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    e         = 0;
    seg_start = 1;
    cur_d     = RD;
    exp_dout  = '0;
    exp_valid = 1'b0;
  endtask

  // Drive one cycle starting from a negedge, advance the model, end on the next negedge.
  task automatic step(input logic [W-1:0] din, input logic ld, input int dly, input logic md);
    int           cnt;
    logic [W-1:0] d, prev;
    din_i   = din;
    load_i  = ld;
    delay_i = 6'(dly);
    mode_i  = md;
    @(posedge clk_i);
    #1;
    e = e + 1;
    hist[e % HN] = din;
    if (ld) begin
      if (dly <= 0)        cur_d = 1;
      else if (dly > DEP)  cur_d = DEP;
      else                 cur_d = dly;
      seg_start = e;
    end
    cnt       = e - seg_start + 1;
    exp_valid = (cnt >= cur_d);
    d         = exp_valid ? hist[(e - cur_d + 1) % HN] : '0;
    prev      = ((e > seg_start) && (cnt - 1 >= cur_d)) ? hist[(e - cur_d) % HN] : '0;
    exp_dout  = md ? (d & ~prev) : d;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (dout_o !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: dout=%h valid=%b want dout=00 valid=0", dout_o, valid_o);
    end
    rst_n_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dout_o !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dout=%h valid=%b want dout=00 valid=0", dout_o, valid_o);
    end
  endtask

  task automatic test_default();
    for (int i = 1; i <= 80; i++) begin
      step((i == 40) ? 8'h01 : 8'h00, 1'b0, 0, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL default e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (i == 31 || i == 32 || i == 71) begin
        checks++;
        if (valid_o !== (i >= 32) || dout_o[0] !== (i == 71)) begin
          errors++;
          $display("FAIL default_mark e=%0d: valid=%b dout0=%b want valid=%b dout0=%b",
                   i, valid_o, dout_o[0], (i >= 32), (i == 71));
        end
      end
    end
  endtask

  task automatic test_load(input int dly, input string name);
    int low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(8'(i + 8'h30), (i == 0), dly, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL %s e=%0d: dout=%h exp=%h valid=%b exp=%b", name, e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (!valid_o) low_cnt++;
    end
    checks++;
    if (low_cnt !== dly - 1) begin
      errors++;
      $display("FAIL %s_lowcount: got %0d want %0d", name, low_cnt, dly - 1);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 110; i++) begin
      step(8'($urandom), (i == 0), 0, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL clamp_zero e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
    end
    for (int i = 0; i < 130; i++) begin
      step(8'($urandom), (i == 0), DEP + 7, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL clamp_max e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (i == 31) begin
        checks++;
        if (valid_o !== 1'b1) begin
          errors++;
          $display("FAIL clamp_max_valid: valid=%b want 1", valid_o);
        end
      end
    end
  endtask

  task automatic test_edge();
    int held_pulses = 0;
    int tog_pulses  = 0;
    for (int i = 0; i < 14; i++) begin
      step(8'h01, (i == 4), 3, 1'b1);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL edge_held e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (i >= 4 && dout_o[0]) held_pulses++;
    end
    checks++;
    if (held_pulses !== 1) begin
      errors++;
      $display("FAIL edge_held_pulses: got %0d want 1", held_pulses);
    end
    for (int i = 0; i < 19; i++) begin
      step((i < 16) ? 8'(i % 2) : 8'h00, 1'b0, 0, 1'b1);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL edge_toggle e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (dout_o[0]) tog_pulses++;
    end
    checks++;
    if (tog_pulses !== 8) begin
      errors++;
      $display("FAIL edge_toggle_pulses: got %0d want 8", tog_pulses);
    end
  endtask

  task automatic test_load_midfill();
    int rise_at = -1;
    for (int i = 0; i < 20; i++) begin
      step(8'(8'hA0 + i), (i == 0 || i == 6), (i == 0) ? 10 : 4, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL midfill e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (valid_o && rise_at < 0) begin
        rise_at = i;
        checks++;
        if (dout_o !== 8'hA6) begin
          errors++;
          $display("FAIL midfill_first: dout=%h want a6", dout_o);
        end
      end
    end
    checks++;
    if (rise_at !== 9) begin
      errors++;
      $display("FAIL midfill_rise: valid rose at step %0d want 9", rise_at);
    end
  endtask

  task automatic test_random_mode();
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom), ($urandom_range(0, 19) == 0), $urandom_range(0, 40), 1'($urandom));
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL random e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(8'hFF, (i == 0), 2, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (dout_o !== '0 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: dout=%h valid=%b want dout=00 valid=0", dout_o, valid_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
    for (int i = 1; i <= 40; i++) begin
      step(8'($urandom), 1'b0, 0, 1'b0);
      checks++;
      if (dout_o !== exp_dout || valid_o !== exp_valid) begin
        errors++;
        $display("FAIL post_reset e=%0d: dout=%h exp=%h valid=%b exp=%b", e, dout_o, exp_dout, valid_o, exp_valid);
      end
      if (i == 31 || i == 32) begin
        checks++;
        if (valid_o !== (i == 32)) begin
          errors++;
          $display("FAIL post_reset_valid e=%0d: valid=%b want %b", i, valid_o, (i == 32));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default();
    test_load(5, "load5");
    test_load(1, "load1");
    test_clamp();
    test_edge();
    test_load_midfill();
    test_random_mode();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_trigout_delay.md
# prog_trigout_delay

Programmable-latency trigger/data delay line: a parametrised successor to the fixed 32-stage 1-bit trigger-out delay chain. It delays a WIDTH-bit bus by a runtime-loadable 1..DEPTH cycles, provides a Valid flag while the new delay fills, and offers an optional rising-edge pulse output mode. It sits in the trigger-out path between trigger generation and the output pin stage, where it aligns trigger outputs with DAC pipeline latency.

## Interface
- WIDTH, 1, number of independent bits (channels) delayed together
- DEPTH, 32, maximum delay in cycles; power of two, ≥2
- RESET_DELAY, 32, delay in effect after reset; 1..DEPTH
- DW, clog2(DEPTH)+1, width of the Delay port (derived; not overridden)
- Clock  in  1  sole clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Din  in  WIDTH  data/trigger input, sampled every edge
- Delay  in  DW  requested latency in cycles; captured only when Load=1
- Load  in  1  one-cycle strobe: capture Delay, restart fill
- Mode  in  1  0 = level (delayed copy), 1 = edge (one-cycle pulse on each delayed 0→1 transition, per bit)
- Dout  out  WIDTH  delayed output, registered
- Valid  out  1  high when Dout reflects post-load samples

## Operation
- Delay register Dreg: reset to RESET_DELAY; on Load, Dreg ← clamp(Delay): 0 → 1, >DEPTH → DEPTH.
- Circular buffer of DEPTH×WIDTH, write pointer wraps modulo DEPTH; Din written every edge, including the Load edge.
- Level mode: Din sampled at edge n appears on Dout after edge n+Dreg−1, i.e. latency exactly Dreg cycles. Dreg=1 behaves as a single register (read of the slot being written is forwarded).
- Fill counter: cleared by reset and by Load; counts edges up to Dreg and saturates there. Valid=1 once the counter reaches Dreg. While Valid=0, Dout is forced to 0; stale pre-load history never appears.
- Edge mode: per bit, Dout[i] = d[i] & ~p[i], where d is the delayed value and p is the previous delayed value. p is cleared by reset and Load, so a level that is already high when Valid rises yields exactly one pulse.
- Mode may change on any cycle. The change takes effect on the next Dout update, and p continues to track regardless of Mode.
- Load during fill: fill restarts with the new Dreg. Load with an unchanged Delay still restarts fill.
- Reset mid-operation: all state returns to reset values immediately and asynchronously.

## Timing
- Reset values: Dout=0, Valid=0, Dreg=RESET_DELAY, wr_ptr=0, fill=0, p=0.
- After reset release, Valid rises after edge RESET_DELAY. Dout then carries Din from the first edge after release.
- Load at edge k: Valid=0 after edges k..k+Dreg−2 and Valid=1 after edge k+Dreg−1. Dout at that point carries the Din sampled at edge k.
- Throughput: one sample per cycle, with no stalls and no backpressure.
- Edge mode adds no latency over level mode.
- Clamping is applied at capture. Dreg is never 0 or greater than DEPTH.

## Structure
- Shared package trigout_pkg:
  - clog2 function
  - MODE_LEVEL/MODE_EDGE constants
  - default DEPTH constant (32)
- Sub-module trigout_delay_ram: WIDTH×DEPTH circular buffer with write pointer, read address = wr_ptr−(Dreg−1) mod DEPTH, and write-to-read forwarding.
- Top level holds:
  - Dreg/clamp logic
  - fill counter / Valid
  - edge detect
  - output register

## Test plan
- Default: WIDTH=1, reset, no Load, single-cycle Din pulse at edge 40 → Dout pulse after edge 71 (latency 32); Valid high from edge 32 after release.
- Load with Delay=5, WIDTH=8, Din = incrementing count → Valid low 4 cycles, then Dout = Din delayed exactly 5 with no gaps; repeat with Delay=1 → latency 1.
- Clamping: Delay=0 → behaves as 1; Delay=DEPTH+7 → behaves as DEPTH; wrap check over ≥3×DEPTH cycles with random data against a reference model.
- Edge mode, Delay=3: Din bit0 held high across a Load → exactly one Dout pulse when Valid rises, and no further pulses while high; 0101 toggling → one pulse per rising edge.
- Load mid-fill (Delay=10, then Delay=4 after 6 cycles) → Valid stays low and rises 4 cycles after the second Load; the first-load data never appears.
- Reset_n asserted mid-stream (asynchronous, between edges) → Dout=0 and Valid=0 immediately; after release, the RESET_DELAY fill repeats.
